// File: rtl/sk6805_chain_driver.sv
// SK6805 single-wire chain driver: frame snapshot, brightness scaling,
// start/busy/done handshake, auto refresh and mandatory latch gaps.
module sk6805_chain_driver #(
    parameter int NUM_LEDS = 8,
    parameter int T_BIT    = 12,
    parameter int T0H      = 3,
    parameter int T1H      = 9,
    parameter int T_RESET  = 1000
) (
    input  logic                    clk_10MHz,
    input  logic                    Rst,
    input  logic [24*NUM_LEDS-1:0]  RGB_Data,
    input  logic [7:0]              Brightness,
    input  logic                    Start,
    input  logic                    Auto_Refresh,
    output logic                    Busy,
    output logic                    Frame_Done,
    output logic                    LED_IO
);

    typedef enum logic [2:0] {
        S_INIT_GAP,
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP
    } state_t;

    localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int GW = (T_RESET > 1) ? $clog2(T_RESET) : 1;
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] C_BIT_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] C_T0H      = CW'(T0H);
    localparam logic [CW-1:0] C_T1H      = CW'(T1H);
    localparam logic [GW-1:0] C_GAP_LAST = GW'(T_RESET - 1);
    localparam logic [LW-1:0] C_LED_LAST = LW'(NUM_LEDS - 1);
    localparam logic [4:0]    C_SUB_LAST = 5'd23;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cyc, w_cyc_nxt;
    logic [GW-1:0]           r_gap, w_gap_nxt;
    logic [LW-1:0]           r_led, w_led_nxt;
    logic [4:0]              r_sub, w_sub_nxt;
    logic [24*NUM_LEDS-1:0]  r_rgb, w_rgb_nxt;
    logic [7:0]              r_bri, w_bri_nxt;
    logic                    r_led_io, w_io_nxt;
    logic                    r_done, w_done_nxt;

    logic [23:0]             w_pix;
    logic [7:0]              w_r_s, w_g_s, w_b_s;
    logic [23:0]             w_grb;
    logic                    w_bit;
    logic [CW-1:0]           w_high_len;

    // Current pixel from the snapshot, scaled and reordered to G,R,B
    assign w_pix  = r_rgb[24*int'(r_led) +: 24];
    assign w_r_s  = 8'((16'(w_pix[23:16]) * (16'(r_bri) + 16'd1)) >> 8);
    assign w_g_s  = 8'((16'(w_pix[15:8])  * (16'(r_bri) + 16'd1)) >> 8);
    assign w_b_s  = 8'((16'(w_pix[7:0])   * (16'(r_bri) + 16'd1)) >> 8);
    assign w_grb  = {w_g_s, w_r_s, w_b_s};
    assign w_bit  = w_grb[C_SUB_LAST - r_sub];
    assign w_high_len = w_bit ? C_T1H : C_T0H;

    assign Busy       = (r_state != S_IDLE);
    assign Frame_Done = r_done;
    assign LED_IO     = r_led_io;

    // Next-state, counters and registered outputs for the following cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_gap_nxt   = r_gap;
        w_led_nxt   = r_led;
        w_sub_nxt   = r_sub;
        w_rgb_nxt   = r_rgb;
        w_bri_nxt   = r_bri;
        w_io_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_INIT_GAP: begin
                if (r_gap == C_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            S_IDLE: begin
                if (Start || Auto_Refresh) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rgb_nxt   = RGB_Data;
                w_bri_nxt   = Brightness;
                w_state_nxt = S_SEND;
                w_cyc_nxt   = '0;
                w_led_nxt   = '0;
                w_sub_nxt   = '0;
                w_io_nxt    = 1'b1;
            end
            S_SEND: begin
                if (r_cyc == C_BIT_LAST) begin
                    w_cyc_nxt = '0;
                    w_io_nxt  = 1'b1;
                    if (r_sub == C_SUB_LAST) begin
                        w_sub_nxt = '0;
                        if (r_led == C_LED_LAST) begin
                            w_state_nxt = S_GAP;
                            w_io_nxt    = 1'b0;
                            w_gap_nxt   = '0;
                            w_led_nxt   = '0;
                        end else begin
                            w_led_nxt = r_led + LW'(1);
                        end
                    end else begin
                        w_sub_nxt = r_sub + 5'd1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CW'(1);
                    w_io_nxt  = ((r_cyc + CW'(1)) < w_high_len);
                end
            end
            S_GAP: begin
                if (r_gap == C_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_INIT_GAP;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_10MHz) begin
        if (!Rst) begin
            r_state  <= S_INIT_GAP;
            r_cyc    <= '0;
            r_gap    <= '0;
            r_led    <= '0;
            r_sub    <= '0;
            r_rgb    <= '0;
            r_bri    <= '0;
            r_led_io <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_gap    <= w_gap_nxt;
            r_led    <= w_led_nxt;
            r_sub    <= w_sub_nxt;
            r_rgb    <= w_rgb_nxt;
            r_bri    <= w_bri_nxt;
            r_led_io <= w_io_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_sk6805_chain_driver.sv
// Bench for sk6805_chain_driver with two LEDs: decodes LED_IO pulses
// and compares against an arithmetic model of scaled GRB frames.
module tb_sk6805_chain_driver;

    localparam int N     = 2;
    localparam int SEND  = 24 * N * 12;
    localparam int FRAME = 2 + SEND + 1000;

    logic             clk;
    logic             rst_n;
    logic [24*N-1:0]  rgb;
    logic [7:0]       bri;
    logic             start;
    logic             auto_r;
    logic             busy;
    logic             done;
    logic             led_io;

    int checks   = 0;
    int failures = 0;

    sk6805_chain_driver #(
        .NUM_LEDS(N),
        .T_BIT(12),
        .T0H(3),
        .T1H(9),
        .T_RESET(1000)
    ) dut (
        .clk_10MHz(clk),
        .Rst(rst_n),
        .RGB_Data(rgb),
        .Brightness(bri),
        .Start(start),
        .Auto_Refresh(auto_r),
        .Busy(busy),
        .Frame_Done(done),
        .LED_IO(led_io)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bit stream: LED0 first, G,R,B each MSB first, scaled
    function automatic logic [47:0] exp_stream(input logic [47:0] d,
                                               input logic [7:0] b);
        logic [47:0] o;
        o = '0;
        for (int led = 0; led < N; led++) begin
            int r, g, bl;
            r  = int'(d[24*led+16 +: 8]);
            g  = int'(d[24*led+8 +: 8]);
            bl = int'(d[24*led +: 8]);
            r  = (r  * (int'(b) + 1)) / 256;
            g  = (g  * (int'(b) + 1)) / 256;
            bl = (bl * (int'(b) + 1)) / 256;
            o  = {o[23:0], g[7:0], r[7:0], bl[7:0]};
        end
        return o;
    endfunction

    // Count INIT_GAP length from the current (reset-state) cycle
    task automatic wait_init(input string tag);
        int n, bad, d, extra;
        n = 0; bad = 0; d = 0; extra = 0;
        for (int i = 0; i < 1100; i++) begin
            if (!busy) break;
            n++;
            if (led_io) bad++;
            if (done) d++;
            if (n == 500) start = 1'b1;
            if (n == 501) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_len"}, n, 1000);
        chk({tag, "_io"}, bad, 0);
        chk({tag, "_done"}, d, 0);
        for (int i = 0; i < 20; i++) begin
            if (busy || done) extra++;
            @(negedge clk);
        end
        chk({tag, "_stay_idle"}, extra, 0);
    endtask

    // Observe one frame whose start condition is sampled at the next edge.
    // act 1: change data and pulse Start at cycle act_k; act 2: drop auto.
    task automatic grab_frame(input string tag, input logic [47:0] exp,
                              input int act_k, input int act);
        logic s [0:SEND-1];
        logic [47:0] got;
        int bad, gap_hi, early, busy_lo, h;
        bad = 0; gap_hi = 0; early = 0; busy_lo = 0;
        got = '0;
        @(posedge clk);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == act_k && act == 1) begin
                rgb   = {$urandom, $urandom};
                bri   = 8'($urandom);
                start = 1'b1;
            end
            if (k == act_k + 1 && act == 1) start = 1'b0;
            if (k == act_k && act == 2) auto_r = 1'b0;
            if (k >= 2 && k < 2 + SEND) s[k-2] = led_io;
            else if (k < FRAME && led_io) gap_hi++;
            if (k < FRAME) begin
                if (done) early++;
                if (!busy) busy_lo++;
            end
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_io_idle"}, led_io, 0);
        for (int i = 0; i < 24 * N; i++) begin
            h = 0;
            for (int p = 0; p < 12; p++) if (s[i*12+p]) h++;
            if (h != 3 && h != 9) bad++;
            for (int p = 0; p < 12; p++)
                if (s[i*12+p] != (p < h)) bad++;
            got[47-i] = (h == 9);
        end
        chk({tag, "_bits"}, got, exp);
        chk({tag, "_shape"}, bad, 0);
        chk({tag, "_low"}, gap_hi, 0);
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_busy"}, busy_lo, 0);
    endtask

    task automatic run_frame(input string tag, input logic [47:0] d,
                             input logic [7:0] b, input int act_k,
                             input int act);
        rgb   = d;
        bri   = b;
        start = 1'b1;
        grab_frame(tag, exp_stream(d, b), act_k, act);
    endtask

    task automatic stay_idle(input string tag, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || done) c++;
        end
        chk(tag, c, 0);
    endtask

    initial begin
        logic [47:0] d;
        rst_n  = 1'b0;
        rgb    = '0;
        bri    = 8'hFF;
        start  = 1'b0;
        auto_r = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_io", led_io, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        wait_init("init");

        run_frame("basic", {24'h000000, 24'hFF00A5}, 8'hFF, 0, 0);
        @(negedge clk);
        run_frame("half", {24'h000000, 24'hFF0000}, 8'h7F, 0, 0);
        @(negedge clk);
        run_frame("zero", {24'h000000, 24'hFF0000}, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            d = {$urandom, $urandom};
            run_frame("rand", d, (i == 0) ? 8'hFF : 8'($urandom), 0, 0);
        end

        @(negedge clk);
        run_frame("snap", {$urandom, $urandom}, 8'($urandom), 300, 1);
        stay_idle("no_queue", 30);

        d      = {$urandom, $urandom};
        rgb    = d;
        bri    = 8'($urandom);
        auto_r = 1'b1;
        grab_frame("auto1", exp_stream(d, bri), 0, 0);
        grab_frame("auto2", exp_stream(d, bri), 0, 0);
        grab_frame("auto3", exp_stream(d, bri), 600, 2);
        stay_idle("auto_stop", 2000);

        rgb   = {$urandom, $urandom};
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 + 30 * 12 + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("pre_rst_io", led_io, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_io", led_io, 0);
        chk("mid_rst_busy", busy, 1);
        rst_n = 1'b1;
        wait_init("reinit");
        d = {$urandom, $urandom};
        run_frame("post_rst", d, 8'($urandom), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
